// File: rtl/perf_monitor_mc.sv
// perf_monitor_mc: multi-channel event-duty monitor with windowed percentages, sticky alarms and saturating counters
module perf_monitor_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count_en,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       event_active,
  input  logic [7:0]              threshold_pct,
  output logic [CNT_W-1:0]        total_cycle_count,
  output logic [NUM_CH*CNT_W-1:0] event_cycle_count,
  output logic [NUM_CH*8-1:0]     window_pct,
  output logic                    pct_valid,
  output logic [NUM_CH-1:0]       alarm,
  output logic                    busy
);
  localparam int DW   = $clog2(WINDOW_LEN*100+1);
  localparam int WC_W = $clog2(WINDOW_LEN+1);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SC_W = $clog2(DW+1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("perf_monitor_mc: NUM_CH must be 1..16");
  end
  if (WINDOW_LEN < NUM_CH*(DW+2)+2) begin : g_bad_window
    $error("perf_monitor_mc: WINDOW_LEN too short for the shared divider");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] cum_q     [NUM_CH];
  logic [WC_W-1:0]  win_cnt_q [NUM_CH];
  logic [WC_W-1:0]  snap_q    [NUM_CH];
  logic [7:0]       shadow_q  [NUM_CH];
  logic [7:0]       pct_q     [NUM_CH];
  logic [WC_W-1:0]  win_pos_q;
  logic [NUM_CH-1:0] alarm_q;
  logic             valid_q;
  logic [CH_W-1:0]  ch_q;
  logic [SC_W-1:0]  sc_q;
  logic [DW-1:0]    dvd_q;
  logic [7:0]       quo_q;
  logic [WC_W-1:0]  rem_q;
  logic [WC_W:0]    r2;
  logic             ge;
  logic             win_close;

  assign win_close = count_en && win_pos_q == WC_W'(WINDOW_LEN-1);
  assign r2        = {rem_q, dvd_q[DW-1]};
  assign ge        = r2 >= (WC_W+1)'(WINDOW_LEN);

  // Free-running cycle/event accounting; the window snapshot includes the closing cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      total_q   <= '0;
      win_pos_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cum_q[i]     <= '0;
        win_cnt_q[i] <= '0;
        snap_q[i]    <= '0;
      end
    end else if (clear) begin
      total_q   <= '0;
      win_pos_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cum_q[i]     <= '0;
        win_cnt_q[i] <= '0;
        snap_q[i]    <= '0;
      end
    end else if (count_en) begin
      total_q   <= total_q + CNT_W'(total_q != '1);
      win_pos_q <= win_close ? '0 : win_pos_q + WC_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        cum_q[i]     <= cum_q[i] + CNT_W'(event_active[i] && cum_q[i] != '1);
        win_cnt_q[i] <= win_close ? '0 : win_cnt_q[i] + WC_W'(event_active[i]);
        if (win_close) snap_q[i] <= win_cnt_q[i] + WC_W'(event_active[i]);
      end
    end

  // Shared restoring divider walks the channels, then publishes all results and alarms together
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      sc_q    <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      alarm_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        pct_q[i]    <= '0;
      end
    end else if (clear) begin
      state_q <= IDLE;
      ch_q    <= '0;
      sc_q    <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      alarm_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        pct_q[i]    <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (win_close) begin
          state_q <= LOAD;
          ch_q    <= '0;
        end
        LOAD: begin
          dvd_q   <= DW'(snap_q[ch_q]) * DW'(100);
          rem_q   <= '0;
          quo_q   <= '0;
          sc_q    <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          dvd_q <= dvd_q << 1;
          rem_q <= ge ? WC_W'(r2 - (WC_W+1)'(WINDOW_LEN)) : r2[WC_W-1:0];
          quo_q <= {quo_q[6:0], ge};
          sc_q  <= sc_q + SC_W'(1);
          if (sc_q == SC_W'(DW-1)) state_q <= STORE;
        end
        STORE: begin
          shadow_q[ch_q] <= quo_q;
          if (ch_q == CH_W'(NUM_CH-1)) state_q <= DONE;
          else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= LOAD;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            pct_q[i] <= shadow_q[i];
            if (shadow_q[i] >= threshold_pct) alarm_q[i] <= 1'b1;
          end
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign event_cycle_count[c*CNT_W +: CNT_W] = cum_q[c];
    assign window_pct[c*8 +: 8]                = pct_q[c];
  end

  assign total_cycle_count = total_q;
  assign pct_valid         = valid_q;
  assign alarm             = alarm_q;
  assign busy              = state_q != IDLE;
endmodule
